eu_alu_opcollect: RTL and testbench



---
 rtl/eu_alu_opcollect_pkg.sv | 25 ++
 rtl/eu_alu_opcollect_if.sv | 13 +
 rtl/eu_alu_opcollect_result_buf.sv | 101 ++++++++++
 rtl/eu_alu_opcollect.sv | 174 +++++++++++++++++
 tb/tb_eu_alu_opcollect.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/eu_alu_opcollect_pkg.sv
// Shared types for the ALU operand-collect execution unit.
package eu_alu_opcollect_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EXEC    = 2'd2
    } eu_state_e;

    function automatic int unsigned cntWidth(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/eu_alu_opcollect_if.sv
// Result pull channel: a consumer asks for an address, the buffer answers one cycle later.
interface eu_alu_opcollect_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              success;
    logic [DATA_W-1:0] data;

    modport master (output req_valid, output req_addr, input success, input data);
    modport slave  (input req_valid, input req_addr, output success, output data);
endinterface

// File: rtl/eu_alu_opcollect_result_buf.sv
// Tagged result buffer: lowest-free allocation, associative consuming pull, hazard lookup.
module eu_result_buf
    import eu_alu_opcollect_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int RBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] query_addr_i,
    output logic              query_hit_o,
    output logic              full_next_o,
    eu_alu_opcollect_if.slave tx_if
);

    localparam int CNT_W = cntWidth(RBUF_DEPTH);
    localparam int IDX_W = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rbuf_entry_t;

    rbuf_entry_t       entry_q [RBUF_DEPTH];
    rbuf_entry_t       entry_d [RBUF_DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              success_q;
    logic [DATA_W-1:0] data_q;

    logic              addrHit;
    logic              pullHit;
    logic [IDX_W-1:0]  hitIdx;
    logic              freeFound;
    logic [IDX_W-1:0]  freeIdx;
    logic              wrFire;

    // Searches use the pre-edge valid set, so a same-cycle write is never visible to a pull.
    always_comb begin
        addrHit     = 1'b0;
        hitIdx      = '0;
        freeFound   = 1'b0;
        freeIdx     = '0;
        query_hit_o = 1'b0;
        for (int i = 0; i < RBUF_DEPTH; i++) begin
            if (!addrHit && entry_q[i].valid && entry_q[i].addr == tx_if.req_addr) begin
                addrHit = 1'b1;
                hitIdx  = IDX_W'(i);
            end
            if (!freeFound && !entry_q[i].valid) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
            if (entry_q[i].valid && entry_q[i].addr == query_addr_i) begin
                query_hit_o = 1'b1;
            end
        end
        pullHit = tx_if.req_valid && addrHit;
        wrFire  = wr_en_i && freeFound;

        for (int i = 0; i < RBUF_DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (pullHit) begin
            entry_d[hitIdx].valid = 1'b0;
        end
        if (wrFire) begin
            entry_d[freeIdx] = '{valid: 1'b1, addr: wr_addr_i, data: wr_data_i};
        end

        count_d     = count_q + CNT_W'(wrFire) - CNT_W'(pullHit);
        full_next_o = (count_d == CNT_W'(RBUF_DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RBUF_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q   <= '0;
            success_q <= 1'b0;
            data_q    <= '0;
        end else begin
            for (int i = 0; i < RBUF_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q   <= count_d;
            success_q <= pullHit;
            data_q    <= pullHit ? entry_q[hitIdx].data : '0;
        end
    end

    assign tx_if.success = success_q;
    assign tx_if.data    = data_q;

endmodule

// File: rtl/eu_alu_opcollect.sv
// ALU execution unit: accepts one instruction, gathers its operands over per-source
// channels, executes, and parks the tagged result in the result buffer.
module eu_alu_opcollect
    import eu_alu_opcollect_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int NUM_SRC    = 2,
    parameter int RBUF_DEPTH = 4,
    parameter int OPC_W      = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      instr_valid_i,
    input  logic [OPC_W-1:0]          instr_opc_i,
    input  logic [ADDR_W-1:0]         instr_dest_i,
    input  logic [NUM_SRC-1:0]        instr_src_used_i,
    input  logic [NUM_SRC*ADDR_W-1:0] instr_src_addr_i,
    output logic                      ready_for_next_instr_o,
    output logic [NUM_SRC-1:0]        icon_rx_req_valid_o,
    output logic [NUM_SRC*ADDR_W-1:0] icon_rx_req_addr_o,
    input  logic [NUM_SRC-1:0]        icon_rx_resp_valid_i,
    input  logic [NUM_SRC*DATA_W-1:0] icon_rx_resp_data_i,
    input  logic                      icon_tx_req_valid_i,
    input  logic [ADDR_W-1:0]         icon_tx_addr_i,
    output logic                      icon_tx_success_o,
    output logic [DATA_W-1:0]         icon_tx_data_o,
    output logic                      busy_o
);

    localparam int SH_W = $clog2(DATA_W);

    eu_state_e                 state_q;
    logic [OPC_W-1:0]          opc_q;
    logic [ADDR_W-1:0]         dest_q;
    logic [NUM_SRC-1:0]        used_q;
    logic [NUM_SRC*ADDR_W-1:0] srcAddr_q;
    logic [NUM_SRC-1:0]        recv_q;
    logic [DATA_W-1:0]         opnd_q [NUM_SRC];
    logic                      ready_q;

    logic [NUM_SRC-1:0] reqVec;
    logic [NUM_SRC-1:0] rxHit;
    logic               accept;
    logic               hazard;
    logic               wrEn;
    logic               fullNext;
    logic [DATA_W-1:0]  srcVal [NUM_SRC];
    logic [DATA_W-1:0]  result;

    eu_alu_opcollect_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) txBus ();

    assign txBus.req_valid = icon_tx_req_valid_i;
    assign txBus.req_addr  = icon_tx_addr_i;
    assign icon_tx_success_o = txBus.success;
    assign icon_tx_data_o    = txBus.data;

    assign reqVec = (state_q == ST_COLLECT) ? (used_q & ~recv_q) : '0;
    assign rxHit  = reqVec & icon_rx_resp_valid_i;
    assign accept = (state_q == ST_IDLE) && instr_valid_i && ready_q;
    assign wrEn   = (state_q == ST_EXEC) && !hazard;

    // Unused sources contribute zero; AND folds only the sources actually used.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            srcVal[i] = used_q[i] ? opnd_q[i] : '0;
        end
    end

    always_comb begin
        logic [DATA_W-1:0] sumAcc;
        logic [DATA_W-1:0] andAcc;
        logic [DATA_W-1:0] orAcc;
        logic [DATA_W-1:0] xorAcc;
        sumAcc = '0;
        andAcc = '1;
        orAcc  = '0;
        xorAcc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sumAcc = sumAcc + srcVal[i];
            orAcc  = orAcc | srcVal[i];
            xorAcc = xorAcc ^ srcVal[i];
            if (used_q[i]) begin
                andAcc = andAcc & opnd_q[i];
            end
        end
        if (used_q == '0) begin
            andAcc = '0;
        end
        case (alu_op_e'(opc_q[2:0]))
            OP_ADD:  result = sumAcc;
            OP_SUB:  result = srcVal[0] - srcVal[1];
            OP_AND:  result = andAcc;
            OP_OR:   result = orAcc;
            OP_XOR:  result = xorAcc;
            OP_SHL:  result = srcVal[0] << srcVal[1][SH_W-1:0];
            OP_SHR:  result = srcVal[0] >> srcVal[1][SH_W-1:0];
            default: result = srcVal[0];
        endcase
    end

    eu_result_buf #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .RBUF_DEPTH (RBUF_DEPTH)
    ) u_result_buf (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en_i      (wrEn),
        .wr_addr_i    (dest_q),
        .wr_data_i    (result),
        .query_addr_i (dest_q),
        .query_hit_o  (hazard),
        .full_next_o  (fullNext),
        .tx_if        (txBus.slave)
    );

    // Ready is registered from the post-edge buffer occupancy, so a pull that frees
    // the last slot raises ready on the very next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            opc_q     <= '0;
            dest_q    <= '0;
            used_q    <= '0;
            srcAddr_q <= '0;
            recv_q    <= '0;
            ready_q   <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                opnd_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        opc_q     <= instr_opc_i;
                        dest_q    <= instr_dest_i;
                        used_q    <= instr_src_used_i;
                        srcAddr_q <= instr_src_addr_i;
                        recv_q    <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= (instr_src_used_i == '0) ? ST_EXEC : ST_COLLECT;
                    end else begin
                        ready_q <= !fullNext;
                    end
                end
                ST_COLLECT: begin
                    recv_q <= recv_q | rxHit;
                    if ((recv_q | rxHit) == used_q) begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wrEn) begin
                        state_q <= ST_IDLE;
                        ready_q <= !fullNext;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            for (int i = 0; i < NUM_SRC; i++) begin
                if (rxHit[i]) begin
                    opnd_q[i] <= icon_rx_resp_data_i[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign ready_for_next_instr_o = ready_q;
    assign icon_rx_req_valid_o    = reqVec;
    assign icon_rx_req_addr_o     = srcAddr_q;
    assign busy_o                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eu_alu_opcollect.sv
// Directed bench for eu_alu_opcollect: opcode vector table plus hand-built
// sequences for staggered operands, full buffer, dest hazard and mid-flight reset.
module tb_eu_alu_opcollect;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instrValid = 1'b0;
    logic [2:0]  instrOpc = '0;
    logic [7:0]  instrDest = '0;
    logic [1:0]  instrUsed = '0;
    logic [15:0] instrSrcAddr = '0;
    logic        ready;
    logic [1:0]  rxReq;
    logic [15:0] rxReqAddr;
    logic [1:0]  rxResp = '0;
    logic [31:0] rxData = '0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    eu_alu_opcollect_if #(.ADDR_W(8), .DATA_W(16)) txIf ();

    always #5 clk = ~clk;

    eu_alu_opcollect #(
        .DATA_W(16), .ADDR_W(8), .NUM_SRC(2), .RBUF_DEPTH(4), .OPC_W(3)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .instr_valid_i          (instrValid),
        .instr_opc_i            (instrOpc),
        .instr_dest_i           (instrDest),
        .instr_src_used_i       (instrUsed),
        .instr_src_addr_i       (instrSrcAddr),
        .ready_for_next_instr_o (ready),
        .icon_rx_req_valid_o    (rxReq),
        .icon_rx_req_addr_o     (rxReqAddr),
        .icon_rx_resp_valid_i   (rxResp),
        .icon_rx_resp_data_i    (rxData),
        .icon_tx_req_valid_i    (txIf.req_valid),
        .icon_tx_addr_i         (txIf.req_addr),
        .icon_tx_success_o      (txIf.success),
        .icon_tx_data_o         (txIf.data),
        .busy_o                 (busy)
    );

    typedef struct {
        logic [2:0]  opc;
        logic [1:0]  used;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [7:0]  dest;
        logic [15:0] expRes;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [2:0] opc, input logic [1:0] used, input logic [7:0] dest,
                            input logic [15:0] srcAddr);
        int n = 0;
        instrValid   = 1'b1;
        instrOpc     = opc;
        instrUsed    = used;
        instrDest    = dest;
        instrSrcAddr = srcAddr;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (!ready) checkOutput("dispatch_timeout", {31'd0, ready}, 32'd1);
        tick();
        instrValid = 1'b0;
    endtask

    // Serves operand requests until the unit stops asking (EXEC) or leaves busy.
    task automatic applyStimulus(input logic [15:0] s0, input logic [15:0] s1, input int dly1);
        int n = 0;
        while (n < 60 && busy && rxReq != 2'b00) begin
            rxResp[0] = rxReq[0];
            rxResp[1] = rxReq[1] && (n >= dly1);
            rxData    = {s1, s0};
            tick();
            rxResp = '0;
            n++;
        end
        if (n >= 60) checkOutput("collect_timeout", {30'd0, rxReq}, 32'd0);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic pull(input logic [7:0] addr, input logic expSucc, input logic [15:0] expData,
                        input string name);
        txIf.req_valid = 1'b1;
        txIf.req_addr  = addr;
        tick();
        txIf.req_valid = 1'b0;
        checkOutput({name, "_succ"}, {31'd0, txIf.success}, {31'd0, expSucc});
        checkOutput({name, "_data"}, {16'd0, txIf.data}, {16'd0, expData});
    endtask

    task automatic runInstr(input logic [2:0] opc, input logic [1:0] used, input logic [7:0] dest,
                            input logic [15:0] s0, input logic [15:0] s1, input string name);
        dispatch(opc, used, dest, 16'h0201);
        applyStimulus(s0, s1, 0);
        waitIdle({name, "_idle"});
    endtask

    initial begin
        txIf.req_valid = 1'b0;
        txIf.req_addr  = '0;

        vecs[0]  = '{3'd0, 2'b11, 16'h0005, 16'h0003, 8'h10, 16'h0008};
        vecs[1]  = '{3'd1, 2'b11, 16'h0000, 16'h0001, 8'h11, 16'hFFFF};
        vecs[2]  = '{3'd5, 2'b11, 16'h0001, 16'h0013, 8'h12, 16'h0008};
        vecs[3]  = '{3'd2, 2'b11, 16'hF0F0, 16'hFF00, 8'h13, 16'hF000};
        vecs[4]  = '{3'd2, 2'b01, 16'h1234, 16'h5555, 8'h14, 16'h1234};
        vecs[5]  = '{3'd3, 2'b01, 16'h00F0, 16'h0F0F, 8'h15, 16'h00F0};
        vecs[6]  = '{3'd4, 2'b11, 16'hAAAA, 16'hFFFF, 8'h16, 16'h5555};
        vecs[7]  = '{3'd6, 2'b11, 16'h8000, 16'h000F, 8'h17, 16'h0001};
        vecs[8]  = '{3'd7, 2'b11, 16'hBEEF, 16'h1234, 8'h18, 16'hBEEF};
        vecs[9]  = '{3'd0, 2'b00, 16'h1111, 16'h2222, 8'h19, 16'h0000};
        vecs[10] = '{3'd2, 2'b00, 16'hFFFF, 16'hFFFF, 8'h1A, 16'h0000};
        vecs[11] = '{3'd0, 2'b11, 16'hFFFF, 16'h0002, 8'h1B, 16'h0001};
        vecs[12] = '{3'd1, 2'b11, 16'h0010, 16'h0003, 8'h1C, 16'h000D};
        vecs[13] = '{3'd3, 2'b11, 16'h0F00, 16'h00F0, 8'h1D, 16'h0FF0};

        #12;
        checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
        checkOutput("rst_ready", {31'd0, ready}, 32'd0);
        checkOutput("rst_req",   {30'd0, rxReq}, 32'd0);
        checkOutput("rst_succ",  {31'd0, txIf.success}, 32'd0);
        checkOutput("rst_data",  {16'd0, txIf.data}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", {31'd0, ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            runInstr(vecs[i].opc, vecs[i].used, vecs[i].dest, vecs[i].s0, vecs[i].s1,
                     $sformatf("vec%0d", i));
            pull(vecs[i].dest, 1'b1, vecs[i].expRes, $sformatf("vec%0d", i));
            if (i == 0) begin
                pull(vecs[i].dest, 1'b0, 16'h0000, "repeat_pull");
                tick();
                checkOutput("no_req_succ", {31'd0, txIf.success}, 32'd0);
            end
        end

        // Channel 1 answers three cycles after channel 0.
        dispatch(3'd0, 2'b11, 8'h50, 16'h0605);
        checkOutput("stag_req0", {30'd0, rxReq}, 32'd3);
        checkOutput("stag_addr", {16'd0, rxReqAddr}, 32'h0605);
        rxResp = 2'b01;
        rxData = {16'h0002, 16'h0007};
        tick();
        rxResp = 2'b00;
        checkOutput("stag_req1", {30'd0, rxReq}, 32'd2);
        tick();
        tick();
        checkOutput("stag_req3", {30'd0, rxReq}, 32'd2);
        rxResp = 2'b10;
        tick();
        rxResp = 2'b00;
        checkOutput("stag_exec_busy", {31'd0, busy}, 32'd1);
        checkOutput("stag_exec_req",  {30'd0, rxReq}, 32'd0);
        tick();
        checkOutput("stag_done", {31'd0, busy}, 32'd0);
        pull(8'h50, 1'b1, 16'h0009, "stag_pull");

        // Fill the buffer, then free a slot in the same cycle as a dispatch attempt.
        for (int k = 0; k < 4; k++) begin
            runInstr(3'd7, 2'b01, 8'(8'h30 + k), 16'(16'hA000 + k), 16'h0000, $sformatf("fill%0d", k));
        end
        checkOutput("full_ready", {31'd0, ready}, 32'd0);
        instrValid     = 1'b1;
        instrOpc       = 3'd7;
        instrUsed      = 2'b01;
        instrDest      = 8'h34;
        txIf.req_valid = 1'b1;
        txIf.req_addr  = 8'h30;
        tick();
        txIf.req_valid = 1'b0;
        checkOutput("free_succ",  {31'd0, txIf.success}, 32'd1);
        checkOutput("free_data",  {16'd0, txIf.data}, 32'hA000);
        checkOutput("free_ready", {31'd0, ready}, 32'd1);
        tick();
        instrValid = 1'b0;
        checkOutput("free_accept", {31'd0, busy}, 32'd1);
        applyStimulus(16'hA004, 16'h0000, 0);
        waitIdle("free_idle");
        for (int k = 1; k < 5; k++) begin
            pull(8'(8'h30 + k), 1'b1, 16'(16'hA000 + k), $sformatf("drain%0d", k));
        end

        // Destination hazard: second result for 0x20 waits until the first is pulled.
        runInstr(3'd7, 2'b01, 8'h20, 16'h1111, 16'h0000, "haz_first");
        dispatch(3'd7, 2'b01, 8'h20, 16'h0201);
        applyStimulus(16'h2222, 16'h0000, 0);
        tick();
        tick();
        tick();
        checkOutput("haz_stall", {31'd0, busy}, 32'd1);
        pull(8'h20, 1'b1, 16'h1111, "haz_old");
        checkOutput("haz_still_busy", {31'd0, busy}, 32'd1);
        pull(8'h20, 1'b0, 16'h0000, "haz_same_cycle");
        checkOutput("haz_written", {31'd0, busy}, 32'd0);
        pull(8'h20, 1'b1, 16'h2222, "haz_new");

        // Reset while collecting with two results buffered.
        runInstr(3'd7, 2'b01, 8'h40, 16'h4040, 16'h0000, "rst_a");
        runInstr(3'd7, 2'b01, 8'h41, 16'h4141, 16'h0000, "rst_b");
        dispatch(3'd0, 2'b11, 8'h42, 16'h0908);
        checkOutput("mid_collect", {30'd0, rxReq}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",  {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_req",   {30'd0, rxReq}, 32'd0);
        checkOutput("mid_rst_addr",  {16'd0, rxReqAddr}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, ready}, 32'd0);
        checkOutput("mid_rst_succ",  {31'd0, txIf.success}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("mid_rel_ready", {31'd0, ready}, 32'd1);
        pull(8'h40, 1'b0, 16'h0000, "rst_pull40");
        pull(8'h41, 1'b0, 16'h0000, "rst_pull41");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
